// File: rtl/pixprobe_sweep_if.sv
`default_nettype none
// ============================================================================
// Module : pixprobe_sweep_if
// Desc   : CPU control bus and probe-master bus of the pixel probe sweeper.
// Rev    : 1.0  initial release
// ============================================================================
interface pixprobe_sweep_if;
    // CPU control bus (sweeper is the slave)
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [2:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;

    // Probe bus (sweeper is the master)
    logic        o_pr_cyc;
    logic        o_pr_stb;
    logic        o_pr_we;
    logic        o_pr_addr;
    logic [31:0] o_pr_data;
    logic        i_pr_ack;
    logic        i_pr_stall;
    logic [31:0] i_pr_data;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data,
        output o_pr_cyc, o_pr_stb, o_pr_we, o_pr_addr, o_pr_data,
        input  i_pr_ack, i_pr_stall, i_pr_data
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data,
        input  o_pr_cyc, o_pr_stb, o_pr_we, o_pr_addr, o_pr_data,
        output i_pr_ack, i_pr_stall, i_pr_data
    );
endinterface
`default_nettype wire

// File: rtl/pixprobe_sweep.sv
`default_nettype none
// ============================================================================
// Module : pixprobe_sweep
// Desc   : Writes a stepped offset to a one-pixel probe, waits, reads a sample
//          back and buffers it; repeats NSAMP times under CPU control.
// Rev    : 1.0  initial release
// ============================================================================
module pixprobe_sweep #(
    parameter int LGBUF = 4
) (
    input  wire             i_clk,
    input  wire             i_reset,
    pixprobe_sweep_if.slave bus,
    output logic            o_int
);
    localparam int             c_DEPTH = 1 << LGBUF;
    localparam logic [LGBUF:0] c_NMAX  = {1'b1, {LGBUF{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR     = 3'd1,
        S_SETTLE = 3'd2,
        S_RD     = 3'd3,
        S_NEXT   = 3'd4
    } state_t;

    state_t           r_state, w_next;
    logic [31:0]      r_start, r_stride, r_settle;
    logic [LGBUF:0]   r_nsamp;
    logic [31:0]      r_offset, r_wstride, r_wsettle, r_timer;
    logic [LGBUF:0]   r_wnsamp, r_count;
    logic [LGBUF-1:0] r_rdptr;
    logic             r_done, r_aborted, r_stb_pend, r_wb_ack, r_int;
    logic [31:0]      r_wb_data;
    logic [31:0]      r_buf [c_DEPTH];

    logic             w_wb_req, w_wr_req, w_rd_req, w_abort, w_start;
    logic             w_fin, w_stb_load, w_pr_cyc, w_pr_stb;
    logic [LGBUF:0]   w_count_inc;
    logic [31:0]      w_rd_data;

    assign w_wb_req    = bus.i_wb_cyc && bus.i_wb_stb;
    assign w_wr_req    = w_wb_req && bus.i_wb_we;
    assign w_rd_req    = w_wb_req && !bus.i_wb_we;
    assign w_abort     = w_wr_req && (bus.i_wb_addr == 3'd0) && bus.i_wb_data[1];
    // abort in the same write suppresses start
    assign w_start     = w_wr_req && (bus.i_wb_addr == 3'd0) && bus.i_wb_data[0]
                         && !bus.i_wb_data[1] && (r_state == S_IDLE);
    assign w_count_inc = r_count + (LGBUF+1)'(1);

    always_comb begin
        w_next     = r_state;
        w_fin      = 1'b0;
        w_stb_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (r_nsamp == '0) begin
                        w_fin = 1'b1;
                    end else begin
                        w_next     = S_WR;
                        w_stb_load = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (w_abort)            w_next = S_IDLE;
                else if (bus.i_pr_ack)  w_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (r_timer == 32'd0) begin
                    w_next     = S_RD;
                    w_stb_load = 1'b1;
                end
            end
            S_RD: begin
                if (w_abort)            w_next = S_IDLE;
                else if (bus.i_pr_ack)  w_next = S_NEXT;
            end
            S_NEXT: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (w_count_inc == r_wnsamp) begin
                    w_next = S_IDLE;
                    w_fin  = 1'b1;
                end else begin
                    w_next     = S_WR;
                    w_stb_load = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Probe bus decodes straight from state so reset drops cyc without a clock
    assign w_pr_cyc       = (r_state == S_WR) || (r_state == S_RD);
    assign w_pr_stb       = w_pr_cyc && r_stb_pend;
    assign bus.o_pr_cyc   = w_pr_cyc;
    assign bus.o_pr_stb   = w_pr_stb;
    assign bus.o_pr_we    = (r_state == S_WR);
    assign bus.o_pr_addr  = (r_state == S_RD);
    assign bus.o_pr_data  = (r_state == S_WR) ? r_offset : 32'd0;
    assign bus.o_wb_stall = 1'b0;
    assign bus.o_wb_ack   = r_wb_ack;
    assign bus.o_wb_data  = r_wb_data;
    assign o_int          = r_int;

    always_comb begin
        w_rd_data = 32'd0;
        case (bus.i_wb_addr)
            3'd0: begin
                w_rd_data[16 +: LGBUF+1] = r_count;
                w_rd_data[2:0]           = {r_aborted, r_done, (r_state != S_IDLE)};
            end
            3'd1:    w_rd_data = r_start;
            3'd2:    w_rd_data = r_stride;
            3'd3:    w_rd_data = 32'(r_nsamp);
            3'd4:    w_rd_data = r_settle;
            3'd5:    w_rd_data = r_buf[r_rdptr];
            3'd6:    w_rd_data = 32'(r_rdptr);
            default: w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_start    <= '0;
            r_stride   <= '0;
            r_nsamp    <= '0;
            r_settle   <= '0;
            r_offset   <= '0;
            r_wstride  <= '0;
            r_wnsamp   <= '0;
            r_wsettle  <= '0;
            r_timer    <= '0;
            r_count    <= '0;
            r_rdptr    <= '0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_stb_pend <= 1'b0;
            r_wb_ack   <= 1'b0;
            r_wb_data  <= '0;
            r_int      <= 1'b0;
        end else begin
            r_int    <= w_fin;
            r_wb_ack <= w_wb_req;

            if (w_wr_req) begin
                case (bus.i_wb_addr)
                    3'd1: r_start  <= bus.i_wb_data;
                    3'd2: r_stride <= bus.i_wb_data;
                    3'd3: r_nsamp  <= (bus.i_wb_data > 32'(c_NMAX)) ? c_NMAX
                                                                      : bus.i_wb_data[LGBUF:0];
                    3'd4: r_settle <= bus.i_wb_data;
                    3'd6: r_rdptr  <= bus.i_wb_data[LGBUF-1:0];
                    default: ;
                endcase
            end

            if (w_rd_req) begin
                r_wb_data <= w_rd_data;
                if (bus.i_wb_addr == 3'd5) r_rdptr <= r_rdptr + LGBUF'(1);
            end

            if (w_start) begin
                r_offset  <= r_start;
                r_wstride <= r_stride;
                r_wnsamp  <= r_nsamp;
                r_wsettle <= r_settle;
                r_done    <= 1'b0;
                r_aborted <= 1'b0;
                r_count   <= '0;
                r_rdptr   <= '0;
            end

            if (w_stb_load)
                r_stb_pend <= 1'b1;
            else if (w_pr_stb && !bus.i_pr_stall)
                r_stb_pend <= 1'b0;

            if (r_state == S_WR && bus.i_pr_ack)
                r_timer <= r_wsettle;
            else if (r_state == S_SETTLE && r_timer != 32'd0)
                r_timer <= r_timer - 32'd1;

            if (r_state == S_NEXT && !w_abort) begin
                r_count  <= w_count_inc;
                r_offset <= r_offset + r_wstride;
            end

            if (w_fin) r_done <= 1'b1;

            if (w_abort && r_state != S_IDLE) begin
                r_aborted <= 1'b1;
                r_done    <= 1'b0;
            end
        end
    end

    // Sample store has no reset; contents after reset are don't-care
    always_ff @(posedge i_clk) begin
        if (r_state == S_RD && bus.i_pr_ack && !w_abort)
            r_buf[r_count[LGBUF-1:0]] <= bus.i_pr_data;
    end
endmodule
`default_nettype wire

// File: tb/tb_pixprobe_sweep.sv
`default_nettype none
// ============================================================================
// Module : tb_pixprobe_sweep
// Desc   : Directed self-checking bench for pixprobe_sweep with a probe model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pixprobe_sweep;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic o_int;

    pixprobe_sweep_if bus();

    pixprobe_sweep #(.LGBUF(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus),
        .o_int   (o_int)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] v;
    logic        last_ack;

    // probe model state, owned by the model process
    logic [31:0] wr_q[$];
    int          n_int = 0, n_acc = 0, stb_wr = 0, cyc_wr = 0;
    int          stall_done = 0, inject_done = 0, dly = 0;
    bit          pend = 1'b0;
    logic [31:0] resp = 32'd0, last_wr = 32'd0;

    // knobs, owned by the stimulus process
    int          stall_req = 0, inject_req = 0, ackdly_wr = 0, ackdly_rd = 0;
    int          b_int, b_acc, b_stb, b_cyc, b_q;
    bit          found;

    // Pipelined probe: accepts stb when not stalled, acks after the set delay,
    // reads return the last written offset + 0xA000.
    always @(negedge clk) begin
        if (rst) begin
            pend           = 1'b0;
            bus.i_pr_ack   = 1'b0;
            bus.i_pr_stall = 1'b0;
            bus.i_pr_data  = 32'd0;
        end else begin
            if (o_int) n_int++;
            if (bus.o_pr_cyc && bus.o_pr_we) cyc_wr++;
            if (bus.o_pr_stb && bus.o_pr_we) stb_wr++;
            bus.i_pr_ack   = 1'b0;
            bus.i_pr_stall = 1'b0;
            if (inject_done != inject_req) begin
                bus.i_pr_ack  = 1'b1;
                bus.i_pr_data = 32'h0000DEAD;
                inject_done++;
            end else if (pend) begin
                if (dly == 0) begin
                    bus.i_pr_ack  = 1'b1;
                    bus.i_pr_data = resp;
                    pend          = 1'b0;
                end else begin
                    dly--;
                end
            end
            if (bus.o_pr_cyc && bus.o_pr_stb && !pend) begin
                if (stall_done < stall_req) begin
                    bus.i_pr_stall = 1'b1;
                    stall_done++;
                end else begin
                    n_acc++;
                    pend = 1'b1;
                    if (bus.o_pr_we) begin
                        wr_q.push_back(bus.o_pr_data);
                        last_wr = bus.o_pr_data;
                        resp    = 32'd0;
                        dly     = ackdly_wr;
                    end else begin
                        resp = last_wr + 32'h0000A000;
                        dly  = ackdly_rd;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b1;
        bus.i_wb_addr = a;   bus.i_wb_data = d;
        @(negedge clk);
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b0;
        bus.i_wb_addr = a;
        @(negedge clk);
        d        = bus.o_wb_data;
        last_ack = bus.o_wb_ack;
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] c;
        c = 32'd1;
        for (int i = 0; i < 400 && c[0]; i++) wb_read(3'd0, c);
        check(tag, {31'd0, c[0]}, 32'd0);
    endtask

    task automatic snap();
        b_int = n_int; b_acc = n_acc; b_stb = stb_wr; b_cyc = cyc_wr; b_q = wr_q.size();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
        bus.i_wb_addr = 3'd0; bus.i_wb_data = 32'd0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_pr_cyc",  32'(bus.o_pr_cyc), 32'd0);
        check("rst_pr_stb",  32'(bus.o_pr_stb), 32'd0);
        check("rst_wb_ack",  32'(bus.o_wb_ack), 32'd0);
        check("rst_wb_data", bus.o_wb_data,     32'd0);
        check("rst_int",     32'(o_int),        32'd0);
        rst = 1'b0;
        wb_read(3'd0, v); check("rst_ctrl", v, 32'd0);
        check("wb_ack", 32'(last_ack), 32'd1);
        @(negedge clk);
        check("wb_ack_single", 32'(bus.o_wb_ack), 32'd0);
        wb_read(3'd1, v); check("rst_start", v, 32'd0);
        wb_read(3'd3, v); check("rst_nsamp", v, 32'd0);

        // basic sweep
        wb_write(3'd1, 32'd100); wb_write(3'd2, 32'd3);
        wb_write(3'd3, 32'd4);   wb_write(3'd4, 32'd2);
        snap();
        wb_write(3'd0, 32'd1);
        wait_done("s1_done");
        check("s1_nwr", 32'(wr_q.size() - b_q), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("s1_off%0d", k), wr_q[b_q + k], 32'(100 + 3 * k));
        wb_read(3'd0, v); check("s1_ctrl", v, 32'h0004_0002);
        check("s1_nint", 32'(n_int - b_int), 32'd1);
        for (int k = 0; k < 4; k++) begin
            wb_read(3'd5, v);
            check($sformatf("s1_data%0d", k), v, 32'h0000A064 + 32'(3 * k));
        end
        wb_read(3'd6, v); check("s1_rdptr", v, 32'd4);

        // offset wrap
        wb_write(3'd1, 32'hFFFF_FFFE); wb_write(3'd2, 32'd1);
        wb_write(3'd3, 32'd3);         wb_write(3'd4, 32'd0);
        snap();
        wb_write(3'd0, 32'd1);
        wait_done("s2_done");
        check("s2_off0", wr_q[b_q],     32'hFFFF_FFFE);
        check("s2_off1", wr_q[b_q + 1], 32'hFFFF_FFFF);
        check("s2_off2", wr_q[b_q + 2], 32'h0000_0000);
        wb_read(3'd5, v); check("s2_data0", v, 32'h0000_9FFE);
        wb_read(3'd5, v);
        wb_read(3'd5, v); check("s2_data2", v, 32'h0000_A000);

        // stalled and late-acked write
        wb_write(3'd1, 32'h55); wb_write(3'd3, 32'd1);
        stall_req = stall_req + 5; ackdly_wr = 3;
        snap();
        wb_write(3'd0, 32'd1);
        wait_done("s3_done");
        ackdly_wr = 0;
        check("s3_stb_cycles", 32'(stb_wr - b_stb), 32'd6);
        check("s3_cyc_cycles", 32'(cyc_wr - b_cyc), 32'd10);
        check("s3_ntxn",       32'(n_acc - b_acc),  32'd2);
        check("s3_off",        wr_q[b_q],           32'h55);
        wb_read(3'd5, v); check("s3_data", v, 32'h0000_A055);

        // clamp, full buffer, start while busy
        wb_write(3'd3, 32'd40);
        wb_read(3'd3, v); check("s4_clamp", v, 32'd16);
        wb_write(3'd1, 32'h1000); wb_write(3'd2, 32'h10); wb_write(3'd4, 32'd1);
        snap();
        wb_write(3'd0, 32'd1);
        wb_write(3'd1, 32'h9999);
        wb_write(3'd0, 32'd1);
        wait_done("s4_done");
        check("s4_nwr",  32'(wr_q.size() - b_q), 32'd16);
        check("s4_off0", wr_q[b_q],      32'h1000);
        check("s4_offF", wr_q[b_q + 15], 32'h10F0);
        wb_read(3'd0, v); check("s4_ctrl", v, 32'h0010_0002);
        check("s4_nint", 32'(n_int - b_int), 32'd1);
        wb_write(3'd6, 32'd15);
        wb_read(3'd5, v); check("s4_data15", v, 32'h0000_B0F0);
        wb_read(3'd6, v); check("s4_rdptr_wrap", v, 32'd0);

        // abort in SETTLE of the third sample, then a stray ack
        wb_write(3'd1, 32'd0); wb_write(3'd2, 32'd1);
        wb_write(3'd3, 32'd4); wb_write(3'd4, 32'd20);
        snap();
        wb_write(3'd0, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (wr_q.size() - b_q == 3 && !bus.o_pr_cyc) found = 1'b1;
        end
        check("s5_reach_settle", 32'(found), 32'd1);
        wb_write(3'd0, 32'd2);
        check("s5_cyc", 32'(bus.o_pr_cyc), 32'd0);
        wb_read(3'd0, v); check("s5_ctrl", v, 32'h0002_0004);
        inject_req++;
        repeat (3) @(negedge clk);
        check("s5_nint", 32'(n_int - b_int), 32'd0);
        wb_read(3'd5, v); check("s5_data0", v, 32'h0000_A000);
        wb_read(3'd5, v); check("s5_data1", v, 32'h0000_A001);
        wb_read(3'd5, v); check("s5_data2", v, 32'h0000_B020);

        // start and abort together in IDLE
        wb_write(3'd3, 32'd2);
        snap();
        wb_write(3'd0, 32'd3);
        repeat (4) @(negedge clk);
        wb_read(3'd0, v); check("s6_ctrl", v, 32'h0002_0004);
        check("s6_ntxn", 32'(n_acc - b_acc), 32'd0);

        // NSAMP = 0
        wb_write(3'd3, 32'd0);
        snap();
        wb_write(3'd0, 32'd1);
        check("s7_int_hi", 32'(o_int), 32'd1);
        @(negedge clk);
        check("s7_int_lo", 32'(o_int), 32'd0);
        wb_read(3'd0, v); check("s7_ctrl", v, 32'h0000_0002);
        check("s7_ntxn", 32'(n_acc - b_acc), 32'd0);

        // reset during a read transaction
        wb_write(3'd1, 32'd7); wb_write(3'd3, 32'd1); wb_write(3'd4, 32'd0);
        ackdly_rd = 10;
        wb_write(3'd0, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.o_pr_cyc && bus.o_pr_addr) found = 1'b1;
        end
        check("s8_reach_rd", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("s8_cyc", 32'(bus.o_pr_cyc), 32'd0);
        check("s8_stb", 32'(bus.o_pr_stb), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ackdly_rd = 0;
        wb_read(3'd0, v); check("s8_ctrl",  v, 32'd0);
        wb_read(3'd1, v); check("s8_start", v, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pixprobe_sweep.md
PIXPROBE_SWEEP -- requirements
Module: pixprobe_sweep

Interface
REQ-001 SHALL have parameter LGBUF, default 4, log2 of the sample buffer depth (16 entries of 32 bits).
REQ-002 SHALL have port i_clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have slave inputs i_wb_cyc, i_wb_stb, i_wb_we (1 each), i_wb_addr (3), i_wb_data (32), used for control by the CPU.
REQ-005 SHALL have slave outputs o_wb_ack (1), o_wb_stall (1), o_wb_data (32).
REQ-006 SHALL have probe-master outputs o_pr_cyc, o_pr_stb, o_pr_we (1 each), o_pr_addr (1), o_pr_data (32), driving the one-pixel probe's bus port.
REQ-007 SHALL have probe-master inputs i_pr_ack (1), i_pr_stall (1), i_pr_data (32).
REQ-008 SHALL have output o_int, 1, a one-cycle pulse when a sweep completes.

Function
REQ-009 Slave: o_wb_stall SHALL be 0; o_wb_ack SHALL assert exactly one cycle after each i_wb_stb; o_wb_data SHALL be registered and valid with the ack.
REQ-010 Register map:
- 0 CTRL: write bit0=start, bit1=abort; read {count[LGBUF:0] at [23:16], aborted[2], done[1], busy[0]}.
- 1 START: start offset.
- 2 STRIDE: offset increment.
- 3 NSAMP: sample count; writes above 2^LGBUF SHALL be clamped to 2^LGBUF.
- 4 SETTLE: wait cycles after each offset write.
- 5 DATA: read returns buf[rdptr], then rdptr increments, wrapping at 2^LGBUF.
- 6 RDPTR: read/write of rdptr.
- 7: reads 0.
REQ-011 Start, accepted only in IDLE, SHALL:
- latch START, STRIDE, NSAMP and SETTLE into working copies;
- clear done, aborted, count and rdptr.
Later register writes SHALL NOT affect a running sweep.
REQ-012 Start while busy SHALL be ignored; start with NSAMP=0 SHALL set done, pulse o_int the next cycle, and generate no probe traffic.
REQ-013 FSM states SHALL be IDLE, WR, SETTLE, RD, NEXT.
REQ-014 WR: o_pr_cyc=1, o_pr_stb=1, o_pr_we=1, o_pr_addr=0, o_pr_data=current offset.
- o_pr_stb SHALL drop on the first cycle with i_pr_stall=0.
- o_pr_cyc SHALL stay high until i_pr_ack, then go low.
- Then go to SETTLE with the timer loaded with the settle copy.
REQ-015 SETTLE: the timer SHALL decrement each cycle; RD is entered on the cycle after the timer reads 0 (SETTLE=0 gives one SETTLE cycle).
REQ-016 RD: o_pr_we=0, o_pr_addr=1, same stb/stall/ack rules as WR; on i_pr_ack, i_pr_data SHALL be written to buf[count].
REQ-017 NEXT (one cycle):
- count += 1, offset += stride, modulo 2^32.
- If count equals NSAMP, go IDLE: busy=0, done=1, o_int pulses for one cycle.
- Otherwise go to WR.
REQ-018 At most one probe transaction SHALL be outstanding; o_pr_cyc SHALL be 0 in IDLE, SETTLE and NEXT.
REQ-019 Abort in any non-IDLE state SHALL:
- drop o_pr_cyc and o_pr_stb on the next cycle and go IDLE;
- set aborted=1, done=0, with no o_int;
- preserve buffered samples and count.
Abort in IDLE SHALL be a no-op.
REQ-020 Start and abort written in the same cycle: abort SHALL win; start SHALL be ignored.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Slave reads of DATA during a sweep SHALL return current buffer contents without disturbing the sweep.
REQ-023 An ack arriving in IDLE (after an abort) SHALL be ignored and SHALL NOT write the buffer.

Reset
REQ-024 i_reset SHALL asynchronously force:
- FSM to IDLE;
- all o_pr_* outputs, o_wb_ack, o_wb_data, o_int to 0;
- START, STRIDE, NSAMP, SETTLE, count, rdptr, done, aborted to 0.
Buffer contents are undefined after reset.
REQ-025 Reset mid-transaction SHALL drop o_pr_cyc immediately and SHALL NOT require a pending ack.

Verification
REQ-026 START=100, STRIDE=3, NSAMP=4, SETTLE=2, zero-wait probe model returning offset+0xA000 -> writes 100,103,106,109; DATA reads 0xA064,0xA067,0xA06A,0xA06D; one o_int; CTRL reads count=4, done=1.
REQ-027 START=0xFFFFFFFE, STRIDE=1, NSAMP=3 -> written offsets 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-028 i_pr_stall held high 5 cycles in WR, ack delayed 3 cycles -> stb held for the stall period, cyc held until ack, one transaction, correct sample stored.
REQ-029 NSAMP write of 40 with LGBUF=4 -> reads back 16; sweep stores 16 samples; second start while busy is ignored (offsets unchanged).
REQ-030 Abort during SETTLE of the 3rd sample -> IDLE next cycle, aborted=1, count=2, no o_int; a late i_pr_ack does not alter buf.
REQ-031 i_reset asserted during RD with cyc high -> o_pr_cyc=0 immediately; after release CTRL reads 0 and START reads 0.
